// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared MIPS decode constants: opcodes, instruction field positions, widths
package cpu_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;

  localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Logical immediates are unsigned; sltiu compares against a zero-extended value here too.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_SLTIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction
endpackage

// File: rtl/decode32_regfile_if.sv
// rtl/decode32_regfile_if.sv - decode stage bundle: fetch/control/write-back inputs and operand outputs
interface decode32_regfile_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] Instruction;
  logic [DATA_W-1:0] link_addr;
  logic [DATA_W-1:0] ALU_result;
  logic [DATA_W-1:0] mem_io_data;
  logic              Jal;
  logic              RegWrite;
  logic              MemorIOtoReg;
  logic              RegDst;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [DATA_W-1:0] Sign_extend;

  modport master (
    output Instruction, link_addr, ALU_result, mem_io_data,
    output Jal, RegWrite, MemorIOtoReg, RegDst,
    input  read_data_1, read_data_2, Sign_extend
  );

  modport slave (
    input  Instruction, link_addr, ALU_result, mem_io_data,
    input  Jal, RegWrite, MemorIOtoReg, RegDst,
    output read_data_1, read_data_2, Sign_extend
  );
endinterface

// File: rtl/decode32_regfile_regfile_32x32.sv
// rtl/decode32_regfile_regfile_32x32.sv - 32x32 register file, 2 async reads, 1 sync write, $0 hardwired
// Optional write-to-read bypass under DECODE_WB_BYPASS_EN.
module regfile_32x32
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);
  logic [DATA_W-1:0] r_regs [REG_NUM];
  logic [DATA_W-1:0] w_stored1;
  logic [DATA_W-1:0] w_stored2;
  logic              w_wr_live;

  assign w_wr_live = i_we && (i_waddr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign w_stored1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign w_stored2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

`ifdef DECODE_WB_BYPASS_EN
  assign o_rdata1 = (w_wr_live && (i_waddr == i_raddr1)) ? i_wdata : w_stored1;
  assign o_rdata2 = (w_wr_live && (i_waddr == i_raddr2)) ? i_wdata : w_stored2;
`else
  assign o_rdata1 = w_stored1;
  assign o_rdata2 = w_stored2;
`endif
endmodule

// File: rtl/decode32_regfile.sv
// rtl/decode32_regfile.sv - MIPS decode stage: write-back select, register file, immediate extension
// Optional same-cycle write bypass via DECODE_WB_BYPASS_EN.
module decode32_regfile
  import cpu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  decode32_regfile_if.slave  bus
);
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic [5:0]        w_op;
  logic [15:0]       w_imm;

  assign w_op  = bus.Instruction[OP_MSB:OP_LSB];
  assign w_rs  = bus.Instruction[RS_MSB:RS_LSB];
  assign w_rt  = bus.Instruction[RT_MSB:RT_LSB];
  assign w_rd  = bus.Instruction[RD_MSB:RD_LSB];
  assign w_imm = bus.Instruction[IMM_MSB:IMM_LSB];

  // jal overrides the normal destination and data regardless of RegWrite.
  assign w_we    = bus.RegWrite | bus.Jal;
  assign w_waddr = bus.Jal ? LINK_REG : (bus.RegDst ? w_rd : w_rt);
  assign w_wdata = bus.Jal ? bus.link_addr
                           : (bus.MemorIOtoReg ? bus.mem_io_data : bus.ALU_result);

  assign bus.Sign_extend = is_zero_ext(w_op) ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};

  regfile_32x32 u_regfile (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (bus.read_data_1),
    .o_rdata2 (bus.read_data_2)
  );
endmodule
